// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller: FSM state encoding,
// collision-detector bounce codes and score/counter widths.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] BOUNCE_NONE   = 2'b00;
  localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
  localparam logic [1:0] BOUNCE_WALL   = 2'b10;
  localparam logic [1:0] BOUNCE_GOAL   = 2'b11;

  localparam int SCORE_W = 4;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/pong_match_controller_if.sv
// Event/status bundle between the match controller and its environment
// (collision detector, VGA timing, renderer, ball FSM). Adds pause when PONG_PAUSE_EN is defined.
interface pong_match_controller_if;

  logic                        frame_tick;
  logic                        start;
  logic [1:0]                  bounce;
  logic                        goal_right;
`ifdef PONG_PAUSE_EN
  logic                        pause;
`endif
  logic                        ball_enable;
  logic                        ball_recentre;
  logic                        serve_dir;
  logic [pong_pkg::SCORE_W-1:0] score_player_1;
  logic [pong_pkg::SCORE_W-1:0] score_player_2;
  logic                        game_over;
  logic                        winner;
  logic [2:0]                  state_dbg;

`ifdef PONG_PAUSE_EN
  modport master (
    output frame_tick, start, bounce, goal_right, pause,
    input  ball_enable, ball_recentre, serve_dir, score_player_1,
           score_player_2, game_over, winner, state_dbg
  );
  modport slave (
    input  frame_tick, start, bounce, goal_right, pause,
    output ball_enable, ball_recentre, serve_dir, score_player_1,
           score_player_2, game_over, winner, state_dbg
  );
`else
  modport master (
    output frame_tick, start, bounce, goal_right,
    input  ball_enable, ball_recentre, serve_dir, score_player_1,
           score_player_2, game_over, winner, state_dbg
  );
  modport slave (
    input  frame_tick, start, bounce, goal_right,
    output ball_enable, ball_recentre, serve_dir, score_player_1,
           score_player_2, game_over, winner, state_dbg
  );
`endif

endinterface

// File: rtl/pong_frame_counter.sv
// Loadable down-counter of frame ticks; load wins over tick, and the count
// holds at zero rather than wrapping.
module pong_frame_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick_en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER).
// Owns the scores; all outputs registered. Optional pause input under PONG_PAUSE_EN.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic                    clock,
  input  logic                    reset,
  pong_match_controller_if.slave  bus
);

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_C = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_C = CNT_W'(POINT_FRAMES);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
  endfunction

  state_t             state_q, state_n;
  logic               start_q;
  logic [1:0]         bounce_q;
  logic [SCORE_W-1:0] score1_q, score1_n, score2_q, score2_n;
  logic               serve_dir_q, serve_dir_n;
  logic               game_over_q, game_over_n;
  logic               winner_q, winner_n;
  logic               ball_enable_q, ball_enable_n;
  logic               recentre_q, recentre_n;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic [CNT_W-1:0]   cnt_count;
  logic               cnt_zero;
  logic               cnt_tick;

  logic               pause_act;
  logic               start_edge;
  logic               goal_edge;
  logic               tick_run;
  logic               expire;

`ifdef PONG_PAUSE_EN
  assign pause_act = bus.pause &&
                     ((state_q == SERVE) || (state_q == PLAY) || (state_q == POINT));
`else
  assign pause_act = 1'b0;
`endif

  // Edge detectors track their inputs every cycle, regardless of state or pause.
  assign start_edge = bus.start && !start_q;
  assign goal_edge  = (bus.bounce == BOUNCE_GOAL) && (bounce_q != BOUNCE_GOAL) && !pause_act;
  assign tick_run   = bus.frame_tick && !pause_act;
  assign cnt_tick   = tick_run && ((state_q == SERVE) || (state_q == POINT));
  assign expire     = cnt_tick && (cnt_zero || (cnt_count == CNT_W'(1)));

  pong_frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick_en  (cnt_tick),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n      = state_q;
    score1_n     = score1_q;
    score2_n     = score2_q;
    serve_dir_n  = serve_dir_q;
    game_over_n  = game_over_q;
    winner_n     = winner_q;
    recentre_n   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    unique case (state_q)
      IDLE: begin
        score1_n    = '0;
        score2_n    = '0;
        game_over_n = 1'b0;
        winner_n    = 1'b0;
        if (start_edge) begin
          state_n      = SERVE;
          recentre_n   = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = SERVE_C;
        end
      end
      SERVE: begin
        if (expire) state_n = PLAY;
      end
      PLAY: begin
        // A goal preempts any coincident frame tick; the counter is reloaded.
        if (goal_edge) begin
          if (bus.goal_right) score1_n = sat_inc(score1_q);
          else                score2_n = sat_inc(score2_q);
          serve_dir_n  = bus.goal_right;
          state_n      = POINT;
          cnt_load     = 1'b1;
          cnt_load_val = POINT_C;
        end
      end
      POINT: begin
        if (expire) begin
          if ((score1_q >= WIN_S) || (score2_q >= WIN_S)) begin
            state_n     = OVER;
            game_over_n = 1'b1;
            winner_n    = (score2_q >= WIN_S);
          end else begin
            state_n      = SERVE;
            recentre_n   = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = SERVE_C;
          end
        end
      end
      OVER: begin
        if (start_edge) begin
          state_n     = IDLE;
          score1_n    = '0;
          score2_n    = '0;
          game_over_n = 1'b0;
          winner_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    ball_enable_n = (state_n == PLAY) && !pause_act;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      bounce_q      <= BOUNCE_NONE;
      score1_q      <= '0;
      score2_q      <= '0;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      ball_enable_q <= 1'b0;
      recentre_q    <= 1'b0;
    end else begin
      state_q       <= state_n;
      start_q       <= bus.start;
      bounce_q      <= bus.bounce;
      score1_q      <= score1_n;
      score2_q      <= score2_n;
      serve_dir_q   <= serve_dir_n;
      game_over_q   <= game_over_n;
      winner_q      <= winner_n;
      ball_enable_q <= ball_enable_n;
      recentre_q    <= recentre_n;
    end
  end

  assign bus.ball_enable    = ball_enable_q;
  assign bus.ball_recentre  = recentre_q;
  assign bus.serve_dir      = serve_dir_q;
  assign bus.score_player_1 = score1_q;
  assign bus.score_player_2 = score2_q;
  assign bus.game_over      = game_over_q;
  assign bus.winner         = winner_q;
  assign bus.state_dbg      = state_q;

endmodule
